// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO: first-word fall-through, beat and packet counters.
// Define AXIS_PKT_FIFO_STORE_FWD_EN to hold output until a whole packet is stored.
//
// Ports:
//   axi_aclk, axi_resetn         clock, async active-low reset
//   s_axis_t{data,keep,valid,last}, s_axis_tready   slave stream (in)
//   m_axis_t{data,keep,valid,last}, m_axis_tready   master stream (out)
//   fill_count                   beats currently stored
//   pkt_count                    tlast beats currently stored
module axis_pkt_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  axi_aclk,
    input  logic                  axi_resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CW-1:0]         fill_count,
    output logic [CW-1:0]         pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [AW-1:0] PONE  = AW'(1);

    logic [WW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] fill_q, fill_d, pkt_q, pkt_d;
    logic          rdy_q, rdy_d;
    logic          push, pop, empty;
    logic [WW-1:0] rd_word;

    assign push  = s_axis_tvalid && rdy_q;
    assign pop   = m_axis_tvalid && m_axis_tready;
    assign empty = (fill_q == '0);

    // Head word is masked while empty so outputs read 0 straight out of reset.
    assign rd_word       = empty ? '0 : mem_q[rd_q];
    assign m_axis_tdata  = rd_word[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = rd_word[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tlast  = rd_word[WW-1];
    assign s_axis_tready = rdy_q;
    assign fill_count    = fill_q;
    assign pkt_count     = pkt_q;

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    logic rel_q, rel_d;

    // Release lets a packet longer than the FIFO drain instead of deadlocking.
    always_comb begin
        rel_d = rel_q;
        if (pop && m_axis_tlast) begin
            rel_d = 1'b0;
        end else if (fill_q == FULL && pkt_q == '0) begin
            rel_d = 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rel_q <= 1'b0;
        end else begin
            rel_q <= rel_d;
        end
    end

    assign m_axis_tvalid = !empty && ((pkt_q != '0) || rel_q);
`else
    assign m_axis_tvalid = !empty;
`endif

    always_comb begin
        wr_d   = push ? wr_q + PONE : wr_q;
        rd_d   = pop  ? rd_q + PONE : rd_q;
        fill_d = fill_q;
        pkt_d  = pkt_q;
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + ONE;
            2'b01:   fill_d = fill_q - ONE;
            default: fill_d = fill_q;
        endcase
        unique case ({push && s_axis_tlast, pop && m_axis_tlast})
            2'b10:   pkt_d = pkt_q + ONE;
            2'b01:   pkt_d = pkt_q - ONE;
            default: pkt_d = pkt_q;
        endcase
        // Registered ready: a pop at full re-opens the input one cycle later.
        rdy_d = (fill_d < FULL);
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
            pkt_q  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fill_q <= fill_d;
            pkt_q  <= pkt_d;
            rdy_q  <= rdy_d;
        end
    end

    // Storage is not reset; fill_count alone decides what is live.
    always_ff @(posedge axi_aclk) begin
        if (push) begin
            mem_q[wr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo (DATA_WIDTH=32, DEPTH=16).
// Store-and-forward checks are compiled in with AXIS_PKT_FIFO_STORE_FWD_EN.
module tb_axis_pkt_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic [3:0]  s_keep = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic [4:0]  fill;
    logic [4:0]  pkt;

    int n_pass = 0;
    int n_tot  = 0;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    always #5 clk = ~clk;

    axis_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(16)) dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .s_axis_tdata  (s_data),
        .s_axis_tkeep  (s_keep),
        .s_axis_tvalid (s_valid),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .fill_count    (fill),
        .pkt_count     (pkt)
    );

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic [3:0]  sk;
        logic        sl;
        logic        mr;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
        logic [4:0]  ef;
        logic [4:0]  ep;
        logic        er;
    } vec_t;

    vec_t tbl [10];
    int   ntbl;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [31:0] sd,
                         input logic [3:0] sk, input logic sl,
                         input logic mr);
        s_valid = sv;
        s_data  = sd;
        s_keep  = sk;
        s_last  = sl;
        m_ready = mr;
    endtask

    initial begin
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
        // 3-beat packet, one beat every other cycle, held until tlast lands
        tbl[0] = '{H, 32'hA1, 4'hF, L, H, L, 32'hA1, 4'hF, L, 5'd1, 5'd0, H};
        tbl[1] = '{L, 32'h00, 4'h0, L, H, L, 32'hA1, 4'hF, L, 5'd1, 5'd0, H};
        tbl[2] = '{H, 32'hA2, 4'h3, L, H, L, 32'hA1, 4'hF, L, 5'd2, 5'd0, H};
        tbl[3] = '{L, 32'h00, 4'h0, L, H, L, 32'hA1, 4'hF, L, 5'd2, 5'd0, H};
        tbl[4] = '{H, 32'hA3, 4'h1, H, H, H, 32'hA1, 4'hF, L, 5'd3, 5'd1, H};
        tbl[5] = '{L, 32'h00, 4'h0, L, H, H, 32'hA2, 4'h3, L, 5'd2, 5'd1, H};
        tbl[6] = '{L, 32'h00, 4'h0, L, H, H, 32'hA3, 4'h1, H, 5'd1, 5'd1, H};
        tbl[7] = '{L, 32'h00, 4'h0, L, H, L, 32'h00, 4'h0, L, 5'd0, 5'd0, H};
        ntbl = 8;
`else
        // 0x11..0x44 streamed through with the sink always ready
        tbl[0] = '{H, 32'h11, 4'hF, L, H, H, 32'h11, 4'hF, L, 5'd1, 5'd0, H};
        tbl[1] = '{H, 32'h22, 4'h3, L, H, H, 32'h22, 4'h3, L, 5'd1, 5'd0, H};
        tbl[2] = '{H, 32'h33, 4'hC, L, H, H, 32'h33, 4'hC, L, 5'd1, 5'd0, H};
        tbl[3] = '{H, 32'h44, 4'h1, H, H, H, 32'h44, 4'h1, H, 5'd1, 5'd1, H};
        tbl[4] = '{L, 32'h00, 4'h0, L, H, L, 32'h00, 4'h0, L, 5'd0, 5'd0, H};
        // pkt_count: push-last only, pop-last only, push-last with plain pop
        tbl[5] = '{H, 32'h55, 4'hF, H, L, H, 32'h55, 4'hF, H, 5'd1, 5'd1, H};
        tbl[6] = '{H, 32'h66, 4'h7, L, H, H, 32'h66, 4'h7, L, 5'd1, 5'd0, H};
        tbl[7] = '{H, 32'h77, 4'hF, H, H, H, 32'h77, 4'hF, H, 5'd1, 5'd1, H};
        tbl[8] = '{L, 32'h00, 4'h0, L, H, L, 32'h00, 4'h0, L, 5'd0, 5'd0, H};
        ntbl = 9;
`endif

        // Reset state
        #2;
        chk("rst_m_valid", 32'(m_valid), 32'(L));
        chk("rst_s_ready", 32'(s_ready), 32'(L));
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_pkt", 32'(pkt), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready_pre", 32'(s_ready), 32'(L));
        tick();
        chk("rel_s_ready_edge", 32'(s_ready), 32'(H));

        for (int i = 0; i < ntbl; i++) begin
            drive(tbl[i].sv, tbl[i].sd, tbl[i].sk, tbl[i].sl, tbl[i].mr);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d_data", i), m_data, tbl[i].ed);
            chk($sformatf("v%0d_keep", i), 32'(m_keep), 32'(tbl[i].ek));
            chk($sformatf("v%0d_last", i), 32'(m_last), 32'(tbl[i].el));
            chk($sformatf("v%0d_fill", i), 32'(fill), 32'(tbl[i].ef));
            chk($sformatf("v%0d_pkt", i), 32'(pkt), 32'(tbl[i].ep));
            chk($sformatf("v%0d_ready", i), 32'(s_ready), 32'(tbl[i].er));
        end

        // Fill to full with sink stalled, tlast on the 16th beat
        for (int i = 0; i < 16; i++) begin
            drive(H, 32'h100 + 32'(i), 4'(i), (i == 15), L);
            tick();
            chk($sformatf("full_fill%0d", i), 32'(fill), 32'(i + 1));
            chk($sformatf("full_rdy%0d", i), 32'(s_ready), 32'(i < 15));
        end
        chk("full_pkt", 32'(pkt), 32'd1);
        drive(H, 32'hDEAD, 4'hF, L, L);
        tick();
        chk("full_nopush", 32'(fill), 32'd16);
        chk("full_head", m_data, 32'h100);
        chk("full_head_keep", 32'(m_keep), 32'h0);
        chk("full_valid", 32'(m_valid), 32'(H));
        drive(L, 32'h0, 4'h0, L, H);
        #1;
        chk("full_rdy_not_comb", 32'(s_ready), 32'(L));
        tick();
        chk("pop1_fill", 32'(fill), 32'd15);
        chk("pop1_rdy", 32'(s_ready), 32'(H));
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain_d%0d", i), m_data, 32'h100 + 32'(i));
            chk($sformatf("drain_l%0d", i), 32'(m_last), 32'(i == 15));
            tick();
        end
        chk("drain_fill", 32'(fill), 32'd0);
        chk("drain_pkt", 32'(pkt), 32'd0);

        // Hold 8 beats, then 40 cycles of push+pop with pointer wrap
        for (int i = 0; i < 8; i++) begin
            drive(H, 32'h200 + 32'(i), 4'hF, H, L);
            tick();
        end
        chk("c8_fill", 32'(fill), 32'd8);
        chk("c8_pkt", 32'(pkt), 32'd8);
        for (int k = 0; k < 40; k++) begin
            drive(H, 32'h208 + 32'(k), 4'hF, H, H);
            #1;
            chk($sformatf("c_d%0d", k), m_data, 32'h200 + 32'(k));
            chk($sformatf("c_r%0d", k), 32'(s_ready & m_valid), 32'(H));
            tick();
            chk($sformatf("c_f%0d", k), 32'(fill), 32'd8);
            chk($sformatf("c_p%0d", k), 32'(pkt), 32'd8);
        end
        drive(L, 32'h0, 4'h0, L, H);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("c_tail%0d", i), m_data, 32'h228 + 32'(i));
            tick();
        end
        chk("c_end_fill", 32'(fill), 32'd0);
        chk("c_end_valid", 32'(m_valid), 32'(L));

        // Async reset with 5 beats stored
        for (int i = 0; i < 5; i++) begin
            drive(H, 32'h50 + 32'(i), 4'hF, (i == 2), L);
            tick();
        end
        chk("r5_fill", 32'(fill), 32'd5);
        chk("r5_pkt", 32'(pkt), 32'd1);
        drive(L, 32'h0, 4'h0, L, L);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(m_valid), 32'(L));
        chk("ar_ready", 32'(s_ready), 32'(L));
        chk("ar_fill", 32'(fill), 32'd0);
        chk("ar_pkt", 32'(pkt), 32'd0);
        chk("ar_data", m_data, 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        chk("ar_rdy_pre", 32'(s_ready), 32'(L));
        tick();
        chk("ar_rdy_edge", 32'(s_ready), 32'(H));
        chk("ar_empty", 32'(m_valid), 32'(L));

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
        // 20-beat packet exceeds DEPTH: must drain through release mode
        begin
            int sent;
            int got;
            sent = 0;
            got  = 0;
            for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
                drive(sent < 20, 32'h300 + 32'(sent), 4'hF, (sent == 19), H);
                #1;
                if (m_valid) begin
                    if (got == 0) begin
                        chk("rel_first_fill", 32'(fill), 32'd16);
                        chk("rel_first_pkt", 32'(pkt), 32'd0);
                    end
                    chk($sformatf("rel_d%0d", got), m_data,
                        32'h300 + 32'(got));
                    chk($sformatf("rel_l%0d", got), 32'(m_last),
                        32'(got == 19));
                    got++;
                end
                if (s_valid && s_ready) sent++;
                tick();
            end
            chk("rel_all", 32'(got), 32'd20);
            chk("rel_fill0", 32'(fill), 32'd0);
            chk("rel_pkt0", 32'(pkt), 32'd0);
            drive(H, 32'h400, 4'hF, L, H);
            tick();
            drive(L, 32'h0, 4'h0, L, H);
            #1;
            chk("rel_cleared", 32'(m_valid), 32'(L));
            chk("rel_held", 32'(fill), 32'd1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits (multiple of 8, 8..512).
REQ-002 SHALL have parameter DEPTH, default 16, storage beats (power of two, 2..1024).
REQ-003 SHALL derive local KEEP_WIDTH = DATA_WIDTH/8 and CW = $clog2(DEPTH)+1.
REQ-004 SHALL have port axi_aclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port axi_resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports s_axis_tdata/tkeep/tvalid/tlast  input  DATA_WIDTH/KEEP_WIDTH/1/1  slave stream beat.
REQ-007 SHALL have port s_axis_tready  output  1  slave ready.
REQ-008 SHALL have ports m_axis_tdata/tkeep/tvalid/tlast  output  DATA_WIDTH/KEEP_WIDTH/1/1  master stream beat.
REQ-009 SHALL have port m_axis_tready  input  1  master ready.
REQ-010 SHALL have port fill_count  output  CW  beats currently stored.
REQ-011 SHALL have port pkt_count  output  CW  complete packets (tlast beats) currently stored.

Function
REQ-012 Push SHALL occur on a rising edge when s_axis_tvalid && s_axis_tready; pop when m_axis_tvalid && m_axis_tready.
REQ-013 s_axis_tready SHALL be registered, equal to (fill_count < DEPTH) after each edge; a pop at full re-asserts tready one cycle later, never combinationally.
REQ-014 Storage SHALL be first-word fall-through: a beat pushed at edge N is presentable on m_axis_* after edge N (latency 1 cycle).
REQ-015 m_axis_tdata/tkeep/tlast SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-016 Simultaneous push and pop SHALL leave fill_count unchanged; push-only +1; pop-only -1.
REQ-017 pkt_count SHALL +1 on push with tlast, -1 on pop with tlast, unchanged when both or neither.
REQ-018 Read/write pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0 without gap.
REQ-019 Empty (fill_count==0) SHALL force m_axis_tvalid=0; full (fill_count==DEPTH) SHALL force s_axis_tready=0.
REQ-020 tkeep SHALL be stored and forwarded unmodified; no null-beat removal.

Reset
REQ-021 Asserting axi_resetn low SHALL immediately clear pointers, fill_count, pkt_count, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast and s_axis_tready to 0.
REQ-022 s_axis_tready SHALL rise on the first rising edge after axi_resetn deasserts.
REQ-023 Reset mid-packet SHALL discard all stored beats; storage array contents need not be cleared.

Configuration
REQ-024 Macro AXIS_PKT_FIFO_STORE_FWD_EN SHALL select store-and-forward mode.
REQ-025 With the macro defined, m_axis_tvalid SHALL assert only while pkt_count > 0 or release mode is active.
REQ-026 With the macro defined, release mode SHALL set when fill_count==DEPTH && pkt_count==0 and clear after the tlast beat is popped, preventing deadlock on packets longer than DEPTH.
REQ-027 Without the macro (cut-through), m_axis_tvalid SHALL equal fill_count != 0; pkt_count still SHALL be maintained.

Verification
REQ-028 Reset release, 4 beats 0x11..0x44 tlast on 4th, m_axis_tready=1 -> each beat out 1 cycle after push, same order, tlast on 0x44, fill_count returns 0.
REQ-029 m_axis_tready=0, push 16 beats (DEPTH=16) -> s_axis_tready low after 16th, fill_count=16; one pop -> tready high next cycle, fill_count=15.
REQ-030 Continuous push+pop at fill_count=8 for 40 cycles -> fill_count constant 8, pointers wrap twice, data in order.
REQ-031 STORE_FWD_EN, 3-beat packet pushed 1 beat per 2 cycles -> m_axis_tvalid 0 until cycle after tlast push, then 3 beats back-to-back.
REQ-032 STORE_FWD_EN, 20-beat packet, DEPTH=16 -> release at full with pkt_count=0, all 20 beats delivered, release clears after tlast pop.
REQ-033 axi_resetn pulsed low with 5 beats stored -> m_axis_tvalid, s_axis_tready, fill_count, pkt_count 0 asynchronously; tready 1 first edge after release.
